// File: rtl/s_memory_ksa_sequencer.sv
// s_memory_ksa_sequencer: drives the 256x8 S-memory through RC4 init (S[i]=i) and the key-scheduling swap pass.
module s_memory_ksa_sequencer #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   CLK_50M,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             mem_address,
  output logic [7:0]             mem_data,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [3:0] {
    IDLE, INIT, KSA_RD_I, KSA_WAIT_I, KSA_RD_J, KSA_WAIT_J, KSA_WR_J, KSA_WR_I, DONE
  } state_t;
  state_t state;
  logic [7:0] i, j, si, sj, key_byte, j_next;
  logic [KW-1:0] k;
  // key byte 0 sits in the most-significant byte of secret_key
  always_comb key_byte = 8'(secret_key >> (8 * (KEY_BYTES - 1 - int'(k))));
  always_comb j_next = j + mem_q + key_byte;
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      si <= '0;
      sj <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i <= '0;
          state <= INIT;
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            j <= '0;
            k <= '0;
            state <= KSA_RD_I;
          end
        end
        KSA_RD_I: state <= KSA_WAIT_I;
        KSA_WAIT_I: state <= KSA_RD_J;
        KSA_RD_J: begin
          si <= mem_q;
          j <= j_next;
          state <= KSA_WAIT_J;
        end
        KSA_WAIT_J: state <= KSA_WR_J;
        KSA_WR_J: begin
          sj <= mem_q;
          state <= KSA_WR_I;
        end
        KSA_WR_I: begin
          k <= k == KW'(KEY_BYTES - 1) ? '0 : k + 1'b1;
          if (i == 8'hFF) state <= DONE;
          else begin
            i <= i + 8'd1;
            state <= KSA_RD_I;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    mem_wren = state inside {INIT, KSA_WR_J, KSA_WR_I};
    mem_address = state inside {INIT, KSA_RD_I, KSA_WAIT_I, KSA_WR_I} ? i :
                  state == KSA_RD_J ? j_next :
                  state inside {KSA_WAIT_J, KSA_WR_J} ? j : 8'd0;
    mem_data = state == INIT ? i : state == KSA_WR_J ? si : state == KSA_WR_I ? sj : 8'd0;
  end
endmodule

// File: tb/tb_s_memory_ksa_sequencer.sv
// tb_s_memory_ksa_sequencer: scoreboard bench with a 1-cycle-latency RAM model and an RC4 KSA reference.
module tb_s_memory_ksa_sequencer;
  logic CLK_50M = 0, reset = 1, start = 0;
  logic [23:0] secret_key = '0;
  logic busy, done, mem_wren;
  logic [7:0] mem_address, mem_data, mem_q;
  logic [7:0] ram [256];
  logic [7:0] ms [256];
  int cyc = 0, passed = 0, total = 0;
  typedef struct {int t; logic dn; logic [7:0] a; logic [7:0] d;} ev_t;
  typedef struct {int t; int kind; logic [2:0] f; logic [7:0] a; logic [7:0] d; string nm;} pr_t;
  ev_t sb [$];
  pr_t pq [$];
  ev_t e;
  pr_t p;
  logic [10:0] got, want;
  int adr [12] = '{0, 0, 1, 1, 1, 0, 1, 1, 3, 3, 3, 1};
  logic wrn [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};

  s_memory_ksa_sequencer #(.KEY_BYTES(3)) dut (
    .CLK_50M(CLK_50M), .reset(reset), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #10 CLK_50M = ~CLK_50M;

  always @(posedge CLK_50M) begin
    cyc <= cyc + 1;
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // monitor: write/done events against the scoreboard, then any timed probes due this cycle
  always @(negedge CLK_50M) begin
    if (!reset && (mem_wren || done)) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL extra_event cyc=%0d done=%b addr=%h data=%h, required none", cyc, done, mem_address, mem_data);
      else begin
        e = sb.pop_front();
        if (e.t == cyc && e.dn == done && (e.dn || (e.a == mem_address && e.d == mem_data))) passed++;
        else $display("FAIL %s cyc=%0d done=%b addr=%h data=%h, required cyc=%0d done=%b addr=%h data=%h",
                      e.dn ? "done_event" : "write_event", cyc, done, mem_address, mem_data, e.t, e.dn, e.a, e.d);
      end
    end
    while (pq.size() != 0 && pq[0].t <= cyc) begin
      p = pq.pop_front();
      total++;
      if (p.kind == 0) begin
        got = {busy, done, mem_wren, mem_address};
        want = {p.f, p.a};
      end else if (p.kind == 1) begin
        got = {3'b000, ram[p.a]};
        want = {3'b000, p.d};
      end else begin
        got = 11'(sb.size());
        want = '0;
      end
      if (got == want) passed++;
      else $display("FAIL %s cyc=%0d addr_idx=%h got %h required %h", p.nm, cyc, p.a, got, want);
    end
  end

  task automatic pp(input int t, input int kind, input logic [2:0] f, input logic [7:0] a, input logic [7:0] d, input string nm);
    pq.push_back('{t, kind, f, a, d, nm});
  endtask

  task automatic push_ev(input int t, input logic dn, input logic [7:0] a, input logic [7:0] d, input int upto);
    if (t < upto) sb.push_back('{t, dn, a, d});
  endtask

  // reference RC4 KSA; cycle k of a run is cyc == base + k
  task automatic push_run(input logic [23:0] key, input int base, input int upto);
    logic [7:0] s [256];
    logic [7:0] j, jn, ti, tj, kb;
    for (int n = 0; n < 256; n++) begin
      s[n] = 8'(n);
      push_ev(base + 1 + n, 1'b0, 8'(n), 8'(n), upto);
    end
    j = '0;
    for (int n = 0; n < 256; n++) begin
      kb = 8'(key >> (8 * (2 - n % 3)));
      jn = j + s[n] + kb;
      ti = s[n];
      tj = s[jn];
      push_ev(base + 261 + 6 * n, 1'b0, jn, ti, upto);
      push_ev(base + 262 + 6 * n, 1'b0, 8'(n), tj, upto);
      s[n] = tj;
      s[jn] = ti;
      j = jn;
    end
    push_ev(base + 1793, 1'b1, 8'd0, 8'd0, upto);
    ms = s;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK_50M);
  endtask

  task automatic accept(input logic [23:0] key, output int b);
    @(negedge CLK_50M);
    secret_key = key;
    start = 1;
    @(posedge CLK_50M);
    #1;
    b = cyc - 1;
  endtask

  initial begin
    int b, b3;
    @(negedge CLK_50M);
    pp(cyc + 1, 0, 3'b000, 8'd0, 8'd0, "reset_state");
    pp(cyc + 2, 0, 3'b000, 8'd0, 8'd0, "idle_after_reset");
    @(negedge CLK_50M);
    reset = 0;
    // run 1: all-zero key
    accept(24'h000000, b);
    start = 0;
    push_run(24'h000000, b, 1 << 30);
    pp(b + 1, 0, 3'b101, 8'h00, 8'd0, "init_first");
    pp(b + 256, 0, 3'b101, 8'hFF, 8'd0, "init_last");
    pp(b + 257, 0, 3'b100, 8'h00, 8'd0, "ksa_first_rd");
    pp(b + 1793, 0, 3'b110, 8'd0, 8'd0, "done_cycle");
    pp(b + 1794, 0, 3'b000, 8'd0, 8'd0, "idle_after_done");
    wait_cyc(b + 1800);
    // run 2: key 010203, start re-pressed mid-run and held through DONE
    accept(24'h010203, b);
    start = 0;
    push_run(24'h010203, b, 1 << 30);
    for (int n = 0; n < 12; n++)
      pp(b + 257 + n, 0, {2'b10, wrn[n]}, 8'(adr[n]), 8'd0, "ksa_iter_addr");
    pp(b + 1793, 0, 3'b110, 8'd0, 8'd0, "done_held_start");
    pp(b + 1794, 0, 3'b000, 8'd0, 8'd0, "idle_held_start");
    pp(b + 1795, 0, 3'b101, 8'd0, 8'd0, "reinit_start");
    wait_cyc(b + 500);
    start = 1;
    b3 = b + 1794;
    push_run(24'h010203, b3, 1 << 30);
    wait_cyc(b3 + 6);
    start = 0;
    pp(b3 + 1793, 0, 3'b110, 8'd0, 8'd0, "done_rerun");
    pp(b3 + 1794, 0, 3'b000, 8'd0, 8'd0, "idle_rerun");
    wait_cyc(b3 + 1800);
    // run 4: asynchronous reset in cycle 1000
    accept(24'h000249, b);
    start = 0;
    push_run(24'h000249, b, b + 1000);
    wait_cyc(b + 999);
    pp(b + 1000, 0, 3'b000, 8'd0, 8'd0, "reset_async");
    @(posedge CLK_50M);
    #2 reset = 1;
    repeat (2) @(posedge CLK_50M);
    #3 reset = 0;
    // run 5: full run after reset, RAM against the reference KSA
    accept(24'h000249, b);
    start = 0;
    push_run(24'h000249, b, 1 << 30);
    pp(b + 1793, 0, 3'b110, 8'd0, 8'd0, "done_after_reset");
    pp(b + 1794, 0, 3'b000, 8'd0, 8'd0, "idle_after_reset_run");
    wait_cyc(b + 1799);
    for (int a = 0; a < 256; a++) pp(b + 1800, 1, 3'b000, 8'(a), ms[a], "ram_rc4");
    pp(b + 1801, 2, 3'b000, 8'd0, 8'd0, "scoreboard_empty");
    wait_cyc(b + 1803);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/s_memory_ksa_sequencer.md
# s_memory_ksa_sequencer

Controller that owns the single-port 256x8 S-memory and sequences RC4 state setup. On a start request it runs the initialisation pass (S[i]=i) and then the key-scheduling swap pass (j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]) using a programmable secret key, and reports completion. It sits between the top-level control FSM (switches/keys) and the S-memory RAM, and is the only driver of the RAM address, data and write-enable pins while busy.

## Interface

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; key index wraps modulo KEY_BYTES.

Ports:
- CLK_50M  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request; accepted only in IDLE.
- secret_key  in  8*KEY_BYTES  key; byte 0 = most-significant byte. Must be held stable while busy.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when the KSA pass completes.
- mem_address  out  8  S-memory address.
- mem_data  out  8  S-memory write data.
- mem_wren  out  1  S-memory write enable.
- mem_q  in  8  S-memory read data. One-cycle latency: an address driven in cycle t is valid on mem_q in cycle t+1.

## Operation

- Registers: state, i[7:0], j[7:0], k (key index, 0..KEY_BYTES-1), si[7:0], sj[7:0].
- Outputs are decoded combinationally from state and registers. mem_wren is 1 only in INIT, KSA_WR_J and KSA_WR_I.
- All additions are 8-bit modulo 256. k wraps from KEY_BYTES-1 to 0.
- States:
  - IDLE: busy=0, mem_wren=0, mem_address=0, mem_data=0. If start=1: i=0, go to INIT.
  - INIT: address=i, data=i, wren=1. i++. If i==255: i=0, j=0, k=0, go to KSA_RD_I; else stay.
  - KSA_RD_I: address=i. Go to KSA_WAIT_I.
  - KSA_WAIT_I: address=i. Go to KSA_RD_J.
  - KSA_RD_J: si<=mem_q. j_next = j + mem_q + key[k]. address=j_next, j<=j_next. Go to KSA_WAIT_J.
  - KSA_WAIT_J: address=j. Go to KSA_WR_J.
  - KSA_WR_J: sj<=mem_q. address=j, data=si, wren=1. Go to KSA_WR_I.
  - KSA_WR_I: address=i, data=sj, wren=1. k wraps. If i==255, go to DONE; else i++, go to KSA_RD_I.
  - DONE: done=1, busy=1, wren=0. Go to IDLE.
- Case i==j: the swap writes the same value twice; no special handling.
- start while busy: ignored, not queued. If start is still high in IDLE after DONE, a new run begins.

## Timing

- Reset: state=IDLE; i, j, k, si, sj = 0; busy=0, done=0, mem_wren=0, mem_address=0, mem_data=0. Reset is asynchronous and takes effect mid-operation. RAM contents are then undefined; a fresh start re-runs from INIT.
- Start accepted at edge E0. INIT occupies cycles 1..256 (one write per cycle).
- KSA uses 6 cycles per i: cycles 257..1792.
- done is high in cycle 1793. busy returns low in cycle 1794.
- Earliest re-accept of start is the edge ending cycle 1794.

## Test plan

- Reset, then start with key 0x000000:
  - Writes (addr,data) = (0x00,0x00) in cycle 1 through (0xFF,0xFF) in cycle 256.
  - done occurs exactly once, in cycle 1793.
- Key 0x010203, first KSA iteration (cycles 257-262):
  - Addresses 0,0,1,1,1,0.
  - Writes mem[1]=0x00 in cycle 261, then mem[0]=0x01 in cycle 262.
  - j=0x01 afterwards.
- Key 0x010203, second iteration:
  - Reads S[1]=0x00, giving j = 0x01+0x00+0x02 = 0x03.
  - Writes mem[3]=0x00, then mem[1]=0x03.
- start pulsed again at cycle 500 and held high through DONE:
  - No effect mid-run.
  - New INIT begins in the cycle after IDLE is re-entered.
- Reset asserted at cycle 1000:
  - busy=0 and mem_wren=0 immediately.
  - A subsequent start produces the full 1793-cycle sequence.
- Key 0x000249:
  - After done, a behavioural RC4 KSA model matches all 256 RAM bytes.
